mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, memory address width.
REQ-002 SHALL have parameter DW, default 64, data width; write mask width is DW/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive LS grants while IF waits.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-low (0 = reset).
REQ-006 if_req_valid_i / if_req_ready_o  in/out  1/1  IF fetch request handshake.
REQ-007 if_addr_i  input  AW  fetch address.
REQ-008 ls_req_valid_i / ls_req_ready_o  in/out  1/1  LS request handshake.
REQ-009 ls_addr_i AW, ls_wen_i 1, ls_wdata_i DW, ls_wmask_i DW/8  inputs  LS address, write enable (0 = read), data, byte mask.
REQ-010 mem_req_valid_o / mem_req_ready_i  out/in  1/1  downstream memory request handshake.
REQ-011 mem_addr_o AW, mem_wen_o 1, mem_wdata_o DW, mem_wmask_o DW/8  outputs  registered request fields.
REQ-012 mem_rsp_valid_i / mem_rsp_ready_o  in/out  1/1  memory response handshake; mem_rdata_i DW, mem_rsp_err_i 1 inputs.
REQ-013 if_rsp_valid_o / if_rsp_ready_i, if_rdata_o DW, if_rsp_err_o 1  IF response port.
REQ-014 ls_rsp_valid_o / ls_rsp_ready_i, ls_rdata_o DW, ls_rsp_err_o 1  LS response port.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-016 IDLE: if_req_ready_o / ls_req_ready_o SHALL be 1 only for the selected requester, only in IDLE; all other states 0.
REQ-017 Selection in IDLE: LS wins when both valid, except when starve_cnt == STARVE_MAX, then IF wins.
REQ-018 starve_cnt SHALL increment (saturating at STARVE_MAX) on each LS grant while if_req_valid_i is 1, and clear on any IF grant or when IF grant occurs because LS idle.
REQ-019 On grant, SHALL latch owner (IF/LS) and request fields; IF grants latch wen=0, wdata=0, wmask=0; next state ISSUE.
REQ-020 ISSUE: mem_req_valid_o = 1, fields stable; on mem_req_ready_i = 1 go to WAIT. Minimum grant-to-accept latency 1 cycle.
REQ-021 WAIT: response routed combinationally to owner: owner rsp_valid_o = mem_rsp_valid_i, rdata/err passed through, mem_rsp_ready_o = owner rsp_ready_i; non-owner rsp_valid_o = 0.
REQ-022 On mem_rsp_valid_i & mem_rsp_ready_o in WAIT, SHALL return to IDLE; a new grant is possible the following cycle (no combinational req->grant in WAIT).
REQ-023 mem_rsp_ready_o SHALL be 0 outside WAIT; responses arriving in IDLE/ISSUE are not consumed.
REQ-024 Requester dropping valid in IDLE before handshake SHALL cause no grant and no state change.
REQ-025 mem_req_valid_o SHALL never deassert in ISSUE until accepted.

Reset
REQ-026 On rst_i = 0, asynchronously: state = IDLE, starve_cnt = 0, owner = IF, latched fields = 0.
REQ-027 During reset all valid/ready outputs SHALL be 0; mem_addr_o/wdata/wmask/wen = 0.
REQ-028 Reset mid-transaction SHALL abandon it; no response delivered afterwards until a new grant.

Verification
REQ-029 IF only, addr 0x8000_0000, mem ready immediately, rsp rdata 0x13 after 2 cycles -> if_req_ready_o 1 cycle, mem_req_valid_o next cycle, if_rsp_valid_o with 0x13, back to IDLE.
REQ-030 IF and LS valid same cycle, counter 0 -> LS granted; LS store addr 0x8000_0100 wmask 0xFF reaches mem with wen=1; IF waits.
REQ-031 IF held valid, LS back-to-back 6 requests, STARVE_MAX=4 -> grants LS,LS,LS,LS,IF,LS; counter 0 after IF grant.
REQ-032 mem_req_ready_i held 0 for 5 cycles -> mem_req_valid_o and fields stable all 5 cycles; no new grants.
REQ-033 LS rsp with ls_rsp_ready_i 0 for 3 cycles, mem_rsp_err_i = 1 -> ls_rsp_valid_o/ls_rsp_err_o held, mem_rsp_ready_o 0 until ready, if_rsp_valid_o stays 0.
REQ-034 rst_i asserted in WAIT -> all outputs 0 immediately, state IDLE; later mem_rsp_valid_i not forwarded.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter in front of a single-outstanding memory port.
// LS has priority; a saturating starvation counter forces an IF grant after STARVE_MAX LS wins.
module mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 64,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // fetch request
   input  logic            if_req_valid_i,
   output logic            if_req_ready_o,
   input  logic [AW-1:0]   if_addr_i,
   // load/store request
   input  logic            ls_req_valid_i,
   output logic            ls_req_ready_o,
   input  logic [AW-1:0]   ls_addr_i,
   input  logic            ls_wen_i,
   input  logic [DW-1:0]   ls_wdata_i,
   input  logic [DW/8-1:0] ls_wmask_i,
   // memory request
   output logic            mem_req_valid_o,
   input  logic            mem_req_ready_i,
   output logic [AW-1:0]   mem_addr_o,
   output logic            mem_wen_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_wmask_o,
   // memory response
   input  logic            mem_rsp_valid_i,
   output logic            mem_rsp_ready_o,
   input  logic [DW-1:0]   mem_rdata_i,
   input  logic            mem_rsp_err_i,
   // fetch response
   output logic            if_rsp_valid_o,
   input  logic            if_rsp_ready_i,
   output logic [DW-1:0]   if_rdata_o,
   output logic            if_rsp_err_o,
   // load/store response
   output logic            ls_rsp_valid_o,
   input  logic            ls_rsp_ready_i,
   output logic [DW-1:0]   ls_rdata_o,
   output logic            ls_rsp_err_o
);

   localparam int unsigned MW = DW / 8;
   localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   state_t        state;
   owner_t        owner;
   logic [CW-1:0] starve_cnt;

   logic starved;
   logic sel_if;
   logic sel_ls;
   logic in_idle;
   logic in_wait;
   logic grant_if;
   logic grant_ls;
   logic rsp_done;

   // Requester selection; ready is only offered in IDLE and never while reset is held.
   always_comb begin
      starved  = (starve_cnt == CW'(STARVE_MAX));
      sel_ls   = ls_req_valid_i && !(if_req_valid_i && starved);
      sel_if   = if_req_valid_i && (!ls_req_valid_i || starved);
      in_idle  = rst_i && (state == IDLE);
      in_wait  = (state == WAIT);
      grant_ls = in_idle && sel_ls;
      grant_if = in_idle && sel_if;
   end

   assign if_req_ready_o = grant_if;
   assign ls_req_ready_o = grant_ls;

   // Response path is routed straight through to whoever owns the outstanding transaction.
   always_comb begin
      mem_rsp_ready_o = 1'b0;
      if_rsp_valid_o  = 1'b0;
      if_rdata_o      = '0;
      if_rsp_err_o    = 1'b0;
      ls_rsp_valid_o  = 1'b0;
      ls_rdata_o      = '0;
      ls_rsp_err_o    = 1'b0;
      if (in_wait) begin
         if (owner == OWN_LS) begin
            mem_rsp_ready_o = ls_rsp_ready_i;
            ls_rsp_valid_o  = mem_rsp_valid_i;
            ls_rdata_o      = mem_rdata_i;
            ls_rsp_err_o    = mem_rsp_err_i;
         end else begin
            mem_rsp_ready_o = if_rsp_ready_i;
            if_rsp_valid_o  = mem_rsp_valid_i;
            if_rdata_o      = mem_rdata_i;
            if_rsp_err_o    = mem_rsp_err_i;
         end
      end
   end

   assign rsp_done = mem_rsp_valid_i && mem_rsp_ready_o;

   // Transaction FSM with registered request fields and starvation tracking.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state           <= IDLE;
         owner           <= OWN_IF;
         starve_cnt      <= '0;
         mem_req_valid_o <= 1'b0;
         mem_addr_o      <= '0;
         mem_wen_o       <= 1'b0;
         mem_wdata_o     <= '0;
         mem_wmask_o     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_ls) begin
                  state           <= ISSUE;
                  owner           <= OWN_LS;
                  mem_req_valid_o <= 1'b1;
                  mem_addr_o      <= ls_addr_i;
                  mem_wen_o       <= ls_wen_i;
                  mem_wdata_o     <= ls_wdata_i;
                  mem_wmask_o     <= ls_wmask_i;
                  if (if_req_valid_i && !starved) begin
                     starve_cnt <= starve_cnt + CW'(1);
                  end
               end else if (grant_if) begin
                  state           <= ISSUE;
                  owner           <= OWN_IF;
                  mem_req_valid_o <= 1'b1;
                  mem_addr_o      <= if_addr_i;
                  mem_wen_o       <= 1'b0;
                  mem_wdata_o     <= '0;
                  mem_wmask_o     <= MW'(0);
                  starve_cnt      <= '0;
               end
            end
            ISSUE: begin
               if (mem_req_ready_i) begin
                  state           <= WAIT;
                  mem_req_valid_o <= 1'b0;
               end
            end
            WAIT: begin
               if (rsp_done) begin
                  state <= IDLE;
               end
            end
            default: begin
               state           <= IDLE;
               mem_req_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch path, LS priority, starvation, backpressure, reset abort.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned MW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_valid, if_req_ready;
   logic [AW-1:0] if_addr;
   logic          ls_req_valid, ls_req_ready;
   logic [AW-1:0] ls_addr;
   logic          ls_wen;
   logic [DW-1:0] ls_wdata;
   logic [MW-1:0] ls_wmask;
   logic          mem_req_valid, mem_req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_rsp_valid, mem_rsp_ready;
   logic [DW-1:0] mem_rdata;
   logic          mem_rsp_err;
   logic          if_rsp_valid, if_rsp_ready, if_rsp_err;
   logic [DW-1:0] if_rdata;
   logic          ls_rsp_valid, ls_rsp_ready, ls_rsp_err;
   logic [DW-1:0] ls_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_addr_i(if_addr),
      .ls_req_valid_i(ls_req_valid), .ls_req_ready_o(ls_req_ready), .ls_addr_i(ls_addr),
      .ls_wen_i(ls_wen), .ls_wdata_i(ls_wdata), .ls_wmask_i(ls_wmask),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
      .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
      .mem_rdata_i(mem_rdata), .mem_rsp_err_i(mem_rsp_err),
      .if_rsp_valid_o(if_rsp_valid), .if_rsp_ready_i(if_rsp_ready),
      .if_rdata_o(if_rdata), .if_rsp_err_o(if_rsp_err),
      .ls_rsp_valid_o(ls_rsp_valid), .ls_rsp_ready_i(ls_rsp_ready),
      .ls_rdata_o(ls_rdata), .ls_rsp_err_o(ls_rsp_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      if_req_valid = 0; if_addr = '0;
      ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
      if_rsp_ready = 0; ls_rsp_ready = 0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      rst_n = 1'b0;
      if_req_valid = 1; ls_req_valid = 1;
      #1;
      n_cmp++; if (if_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_if_ready got=%0b exp=0", if_req_ready); end
      n_cmp++; if (ls_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ls_ready got=%0b exp=0", ls_req_ready); end
      tick();
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid got=%0b exp=0", mem_req_valid); end
      n_cmp++; if ({mem_addr, mem_wen, mem_wmask} !== '0) begin n_err++; $display("FAIL rst_mem_fields got=%0h exp=0", {mem_addr, mem_wen, mem_wmask}); end
      n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rst_rsp_ready got=%0b exp=0", mem_rsp_ready); end
      apply_reset();
   endtask

   task automatic test_if_fetch();
      if_req_valid = 1; if_addr = 32'h8000_0000; mem_req_ready = 1; if_rsp_ready = 1;
      #1;
      n_cmp++; if (if_req_ready !== 1'b1) begin n_err++; $display("FAIL if_ready got=%0b exp=1", if_req_ready); end
      n_cmp++; if (ls_req_ready !== 1'b0) begin n_err++; $display("FAIL if_ls_ready got=%0b exp=0", ls_req_ready); end
      tick();
      if_req_valid = 0;
      #1;
      n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL if_mem_valid got=%0b exp=1", mem_req_valid); end
      n_cmp++; if (mem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL if_mem_addr got=%0h exp=80000000", mem_addr); end
      n_cmp++; if (mem_wen !== 1'b0) begin n_err++; $display("FAIL if_mem_wen got=%0b exp=0", mem_wen); end
      n_cmp++; if (if_req_ready !== 1'b0) begin n_err++; $display("FAIL if_ready_issue got=%0b exp=0", if_req_ready); end
      tick();
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL if_mem_valid_wait got=%0b exp=0", mem_req_valid); end
      n_cmp++; if (if_rsp_valid !== 1'b0) begin n_err++; $display("FAIL if_rsp_early got=%0b exp=0", if_rsp_valid); end
      tick();
      mem_rsp_valid = 1; mem_rdata = 64'h13;
      #1;
      n_cmp++; if (if_rsp_valid !== 1'b1) begin n_err++; $display("FAIL if_rsp_valid got=%0b exp=1", if_rsp_valid); end
      n_cmp++; if (if_rdata !== 64'h13) begin n_err++; $display("FAIL if_rdata got=%0h exp=13", if_rdata); end
      n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_err++; $display("FAIL if_rsp_ready got=%0b exp=1", mem_rsp_ready); end
      n_cmp++; if (ls_rsp_valid !== 1'b0) begin n_err++; $display("FAIL if_ls_rsp got=%0b exp=0", ls_rsp_valid); end
      tick();
      mem_rsp_valid = 0;
      #1;
      n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL idle_rsp_ready got=%0b exp=0", mem_rsp_ready); end
      // Request withdrawn before the clock edge must not be granted.
      if_req_valid = 1;
      #1;
      n_cmp++; if (if_req_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready_on got=%0b exp=1", if_req_ready); end
      if_req_valid = 0;
      tick();
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_grant got=%0b exp=0", mem_req_valid); end
      if_req_valid = 1;
      #1;
      n_cmp++; if (if_req_ready !== 1'b1) begin n_err++; $display("FAIL drop_still_idle got=%0b exp=1", if_req_ready); end
      if_req_valid = 0;
      apply_reset();
   endtask

   task automatic test_ls_priority();
      if_req_valid = 1; if_addr = 32'h8000_0040;
      ls_req_valid = 1; ls_addr = 32'h8000_0100; ls_wen = 1;
      ls_wdata = 64'hDEAD_BEEF_CAFE_F00D; ls_wmask = 8'hFF;
      mem_req_ready = 1; ls_rsp_ready = 1; if_rsp_ready = 1;
      #1;
      n_cmp++; if ({if_req_ready, ls_req_ready} !== 2'b01) begin n_err++; $display("FAIL prio_ready got=%0b exp=01", {if_req_ready, ls_req_ready}); end
      tick();
      ls_req_valid = 0;
      #1;
      n_cmp++; if (mem_addr !== 32'h8000_0100) begin n_err++; $display("FAIL prio_addr got=%0h exp=80000100", mem_addr); end
      n_cmp++; if (mem_wen !== 1'b1) begin n_err++; $display("FAIL prio_wen got=%0b exp=1", mem_wen); end
      n_cmp++; if (mem_wmask !== 8'hFF) begin n_err++; $display("FAIL prio_wmask got=%0h exp=ff", mem_wmask); end
      n_cmp++; if (mem_wdata !== 64'hDEAD_BEEF_CAFE_F00D) begin n_err++; $display("FAIL prio_wdata got=%0h exp=deadbeefcafef00d", mem_wdata); end
      n_cmp++; if (if_req_ready !== 1'b0) begin n_err++; $display("FAIL prio_if_waits got=%0b exp=0", if_req_ready); end
      tick();
      mem_rsp_valid = 1; mem_rdata = 64'h0;
      #1;
      n_cmp++; if ({if_rsp_valid, ls_rsp_valid} !== 2'b01) begin n_err++; $display("FAIL prio_rsp_route got=%0b exp=01", {if_rsp_valid, ls_rsp_valid}); end
      tick();
      mem_rsp_valid = 0;
      apply_reset();
   endtask

   task automatic test_starvation();
      logic [1:0]    exp_rdy;
      logic [AW-1:0] exp_addr;
      if_req_valid = 1; if_addr = 32'h8000_1000;
      ls_req_valid = 1; ls_wen = 1; ls_wdata = 64'h1; ls_wmask = 8'h0F;
      mem_req_ready = 1; ls_rsp_ready = 1; if_rsp_ready = 1;
      for (int k = 0; k < 6; k++) begin
         ls_addr  = 32'h8000_0200 + 32'(k * 8);
         exp_rdy  = (k == 4) ? 2'b10 : 2'b01;
         exp_addr = (k == 4) ? 32'h8000_1000 : ls_addr;
         #1;
         n_cmp++; if ({if_req_ready, ls_req_ready} !== exp_rdy) begin n_err++; $display("FAIL starve_grant%0d got=%0b exp=%0b", k, {if_req_ready, ls_req_ready}, exp_rdy); end
         tick();
         n_cmp++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL starve_addr%0d got=%0h exp=%0h", k, mem_addr, exp_addr); end
         n_cmp++; if ({mem_wen, mem_wmask} !== ((k == 4) ? 9'h000 : 9'h10F)) begin n_err++; $display("FAIL starve_fields%0d got=%0h", k, {mem_wen, mem_wmask}); end
         if (k == 4) begin
            n_cmp++; if (dut.starve_cnt !== '0) begin n_err++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.starve_cnt); end
         end
         tick();
         mem_rsp_valid = 1;
         tick();
         mem_rsp_valid = 0;
      end
      apply_reset();
   endtask

   task automatic test_backpressure();
      ls_req_valid = 1; ls_addr = 32'h8000_0300; ls_wen = 0; ls_wmask = 8'h00;
      mem_req_ready = 0;
      tick();
      if_req_valid = 1; if_addr = 32'h8000_2000; ls_addr = 32'h8000_0400;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid%0d got=%0b exp=1", c, mem_req_valid); end
         n_cmp++; if (mem_addr !== 32'h8000_0300) begin n_err++; $display("FAIL stall_addr%0d got=%0h exp=80000300", c, mem_addr); end
         n_cmp++; if ({if_req_ready, ls_req_ready} !== 2'b00) begin n_err++; $display("FAIL stall_grant%0d got=%0b exp=00", c, {if_req_ready, ls_req_ready}); end
         tick();
      end
      mem_req_ready = 1;
      tick();
      if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 0;
      mem_rsp_valid = 1; mem_rsp_err = 1; mem_rdata = 64'h55; ls_rsp_ready = 0; if_rsp_ready = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if ({ls_rsp_valid, ls_rsp_err} !== 2'b11) begin n_err++; $display("FAIL bp_ls_rsp%0d got=%0b exp=11", c, {ls_rsp_valid, ls_rsp_err}); end
         n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL bp_rsp_ready%0d got=%0b exp=0", c, mem_rsp_ready); end
         n_cmp++; if (if_rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_if_rsp%0d got=%0b exp=0", c, if_rsp_valid); end
         tick();
      end
      ls_rsp_ready = 1;
      #1;
      n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%0b exp=1", mem_rsp_ready); end
      n_cmp++; if (ls_rdata !== 64'h55) begin n_err++; $display("FAIL bp_rdata got=%0h exp=55", ls_rdata); end
      tick();
      #1;
      n_cmp++; if ({ls_rsp_valid, mem_rsp_ready} !== 2'b00) begin n_err++; $display("FAIL bp_idle got=%0b exp=00", {ls_rsp_valid, mem_rsp_ready}); end
      apply_reset();
   endtask

   task automatic test_reset_mid();
      if_req_valid = 1; if_addr = 32'h8000_3000; mem_req_ready = 1; if_rsp_ready = 1;
      tick();
      if_req_valid = 0;
      tick();
      mem_rsp_valid = 1; mem_rdata = 64'hAA;
      #1;
      n_cmp++; if (if_rsp_valid !== 1'b1) begin n_err++; $display("FAIL abort_pre got=%0b exp=1", if_rsp_valid); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({if_rsp_valid, mem_rsp_ready, mem_req_valid} !== 3'b000) begin n_err++; $display("FAIL abort_outputs got=%0b exp=000", {if_rsp_valid, mem_rsp_ready, mem_req_valid}); end
      n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL abort_addr got=%0h exp=0", mem_addr); end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++; if ({if_rsp_valid, ls_rsp_valid, mem_rsp_ready} !== 3'b000) begin n_err++; $display("FAIL abort_after%0d got=%0b exp=000", c, {if_rsp_valid, ls_rsp_valid, mem_rsp_ready}); end
      end
      mem_rsp_valid = 0;
   endtask

   initial begin
      test_reset();
      test_if_fetch();
      test_ls_priority();
      test_starvation();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
